// File: rtl/fixed_point_pkg.sv
// Shared constants and types for the 16-bit sign-magnitude fixed-point datapath
// (1 sign, 7 integer, 8 fraction bits), used by both the divider and the multiplier.
package fixed_point_pkg;
  localparam int FXP_WIDTH     = 16;
  localparam int FXP_FRAC_BITS = 8;

  typedef logic [FXP_WIDTH-1:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_t;
endpackage

// File: rtl/fixed_point_divide.sv
// Sequential sign-magnitude fixed-point divider, one restoring step per clock.
// Build option FIXED_DIV_SAT_EN: saturate the magnitude on overflow instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on acceptance
// DIVIDE | one restoring quotient bit per cycle, counter runs ITER-1 down to 0
// DONE   | register quotient and flags, pulse done next cycle
module fixed_point_divide
  import fixed_point_pkg::*;
#(
  parameter int WIDTH     = FXP_WIDTH,
  parameter int FRAC_BITS = FXP_FRAC_BITS
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int MAG   = WIDTH - 1;
  localparam int ITER  = WIDTH - 1 + FRAC_BITS;
  localparam int CNT_W = $clog2(ITER);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ITER-1:0]  quo_sh;
  logic [MAG:0]     rem;
  logic [MAG-1:0]   dvs_mag;
  logic             sign_q;

  logic             accept, step, finish;
  logic [MAG:0]     shifted;
  logic [WIDTH:0]   trial;
  logic             bit_ge;
  logic             raw_ovf, zero_div;
  logic [MAG-1:0]   mag_fin;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIVIDE;
      DIVIDE:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && start;
    step   = (state == DIVIDE);
    finish = (state == DONE);
  end

  // Remainder stays below the divisor, so WIDTH bits hold the shifted value.
  always_comb begin
    shifted = {rem[MAG-1:0], quo_sh[ITER-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_mag};
    bit_ge  = ~trial[WIDTH];
  end

  always_comb begin
    raw_ovf  = |quo_sh[ITER-1:MAG];
    zero_div = (dvs_mag == '0);
    mag_fin  = quo_sh[MAG-1:0];
    if (zero_div) mag_fin = '1;
`ifdef FIXED_DIV_SAT_EN
    else if (raw_ovf) mag_fin = '1;
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt         <= '0;
      quo_sh      <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      sign_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish;
      // A new acceptance can coincide with the done cycle; busy must stay high then.
      if (accept) begin
        cnt     <= CNT_W'(ITER - 1);
        rem     <= '0;
        quo_sh  <= {dividend[MAG-1:0], {FRAC_BITS{1'b0}}};
        dvs_mag <= divisor[MAG-1:0];
        sign_q  <= dividend[MAG] ^ divisor[MAG];
        busy    <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (step) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        rem    <= bit_ge ? trial[MAG:0] : shifted;
        quo_sh <= {quo_sh[ITER-2:0], bit_ge};
      end
      if (finish) begin
        quotient    <= {sign_q & (mag_fin != '0), mag_fin};
        overflow    <= raw_ovf & ~zero_div;
        div_by_zero <= zero_div;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_divide.sv
// Scoreboard bench for fixed_point_divide: directed corner cases, ignored-start
// and mid-operation reset scenarios, then randomized operands vs an arithmetic model.
module tb_fixed_point_divide;
  import fixed_point_pkg::*;

  logic   clk = 1'b0;
  logic   n_rst = 1'b1;
  logic   start = 1'b0;
  fixed_t dividend = '0;
  fixed_t divisor = '0;
  logic   busy, done, overflow, div_by_zero;
  fixed_t quotient;

  always #5 clk = ~clk;

  fixed_point_divide dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  typedef struct {
    fixed_t q;
    logic   ovf;
    logic   dz;
    int     acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Real-number division of magnitudes scaled by 2^FRAC, truncated toward zero.
  function automatic exp_t model(input fixed_t a, input fixed_t b, input int acc);
    exp_t e;
    int unsigned nm, dm, q, mag;
    logic neg;
    nm = 32'(a[14:0]) * 256;
    dm = 32'(b[14:0]);
    e.acc = acc;
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    if (dm == 0) begin
      e.dz = 1'b1;
      mag  = 32767;
    end else begin
      q = nm / dm;
      if (q > 32767) begin
        e.ovf = 1'b1;
`ifdef FIXED_DIV_SAT_EN
        mag = 32767;
`else
        mag = q % 32768;
`endif
      end else begin
        mag = q;
      end
    end
    neg = (a[15] ^ b[15]) && (mag != 0);
    e.q = neg ? (16'h8000 | 16'(mag)) : 16'(mag);
    return e;
  endfunction

  always @(negedge clk) begin
    if (n_rst) begin
      if (prev_done) chk("done_width", {31'd0, done}, 32'd0);
      if (done) begin
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual quotient=%0h required no result", quotient);
        end else begin
          mon_e = sb.pop_front();
          chk("quotient", {16'd0, quotient}, {16'd0, mon_e.q});
          chk("overflow", {31'd0, overflow}, {31'd0, mon_e.ovf});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dz});
          chk("latency", cyc - mon_e.acc, 32'd24);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Caller sits at a negedge; start is sampled on the following posedge.
  task automatic issue(input fixed_t a, input fixed_t b, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back(model(a, b, cyc));
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start    = 1'b0;
    dividend = fixed_t'($urandom);
    divisor  = fixed_t'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: actual busy=1 required busy=0 within 100 cycles");
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_quotient"}, {16'd0, quotient}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_div_by_zero"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  fixed_t dir_a[9] = '{16'h0300, 16'h8100, 16'h0100, 16'h8000, 16'h7F00,
                       16'h8200, 16'h0000, 16'h7FFF, 16'hFFFF};
  fixed_t dir_b[9] = '{16'h0200, 16'h0400, 16'h0300, 16'h0100, 16'h0080,
                       16'h8000, 16'h0000, 16'h0001, 16'h7FFF};

  initial begin
    fixed_t ra, rb;
    #1 n_rst = 1'b0;
    #2;
    check_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      wait_idle();
      issue(dir_a[i], dir_b[i], 1'b1);
    end

    // Starts at E0+5 and in the DONE cycle are dropped; E0+25 is accepted.
    wait_idle();
    issue(16'h0300, 16'h0200, 1'b1);
    repeat (4) @(negedge clk);
    issue(16'h7F00, 16'h0001, 1'b0);
    repeat (18) @(negedge clk);
    issue(16'h1234, 16'h0010, 1'b0);
    issue(16'h0100, 16'h0300, 1'b1);

    // Reset in the middle of a division.
    wait_idle();
    issue(16'h0300, 16'h0200, 1'b1);
    repeat (9) @(negedge clk);
    #1;
    n_rst = 1'b0;
    sb.delete();
    #1;
    check_cleared("midreset");
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    wait_idle();
    issue(16'h0300, 16'h0200, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = fixed_t'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = {1'($urandom), 15'd0};
        1, 2:    rb = {1'($urandom), 15'($urandom_range(1, 255))};
        default: rb = fixed_t'($urandom);
      endcase
      wait_idle();
      issue(ra, rb, 1'b1);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    checks++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_divide.md
# fixed_point_divide

Sequential sign-magnitude divider for the 16-bit fixed-point format used across the FFT datapath: 1 sign bit, 7 integer bits, 8 fraction bits. It is the inverse companion to the fixed-point multiplier. It normalises bin magnitudes and scaled twiddle results, producing quotient = dividend / divisor in the same format. It uses one restoring-division iteration per clock, with a start/busy/done handshake.

## Interface
- WIDTH, 16, total word width including sign bit
- FRAC_BITS, 8, fraction bits; integer bits = WIDTH-1-FRAC_BITS
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  request a division; sampled only in IDLE
- dividend  in  WIDTH  sign-magnitude numerator; captured when start is accepted
- divisor  in  WIDTH  sign-magnitude denominator; captured when start is accepted
- busy  out  1  high from the cycle after acceptance until done drops
- done  out  1  one-cycle pulse; quotient and flags are valid from this cycle
- quotient  out  WIDTH  sign-magnitude result; held until the next done
- overflow  out  1  magnitude did not fit in WIDTH-1 bits; held with quotient
- div_by_zero  out  1  divisor magnitude was zero; held with quotient

## Operation
- FSM states:
  - IDLE: on start, latch the operands and go to DIVIDE; counter = ITER-1, where ITER = WIDTH-1+FRAC_BITS (23).
  - DIVIDE: perform one restoring step per cycle, shifting the remainder left, bringing in the next dividend bit, subtracting the divisor magnitude and producing one quotient bit. When counter = 0, go to DONE; otherwise decrement.
  - DONE: register the final quotient and flags, pulse done, then return to IDLE.
- Dividend magnitude is the low WIDTH-1 bits extended by FRAC_BITS zeros (23-bit numerator). Divisor magnitude is the low WIDTH-1 bits.
- Raw quotient is ITER bits wide. Rounding is truncation toward zero.
- Sign = dividend[WIDTH-1] XOR divisor[WIDTH-1]. If the final magnitude is 0, the sign is forced to 0, so the block never outputs negative zero.
- overflow = 1 if raw quotient bits above WIDTH-2 are nonzero.
- div_by_zero = 1 if the divisor magnitude is 0 (either sign of zero). Output is sign|all-ones magnitude in every build, and overflow = 0.
- A start request while busy=1 (DIVIDE or DONE) is ignored and not queued.
- Operand inputs may change freely after acceptance.
- Reset, including mid-operation, returns the FSM to IDLE and clears the counter, remainder and all outputs.

## Timing
- Reset values: busy=0, done=0, quotient=0, overflow=0, div_by_zero=0; FSM in IDLE.
- Acceptance edge E0 (start=1 in IDLE). busy is high during the cycles after E0 through the cycle after E0+24.
- DIVIDE occupies edges E0+1 .. E0+23. DONE is entered at E0+23.
- Outputs are registered at E0+24. done is high for exactly the cycle following E0+24, with busy still high in that cycle.
- busy drops and IDLE is reached after E0+25. The earliest next acceptance is E0+25.
- Latency is fixed at 24 cycles for every operand, including zero divisor. Maximum throughput is one division per 25 cycles.
- No combinational path from any input to any output.

## Configuration
- Macro: FIXED_DIV_SAT_EN.
- Defined: on overflow, quotient magnitude saturates to all ones (0x7FFF with sign).
- Undefined: on overflow, quotient magnitude is the low WIDTH-1 bits of the raw quotient (wrap).
- overflow and div_by_zero flag behaviour is identical in both builds.

## Structure
- Shared package fixed_point_pkg holds:
  - WIDTH and FRAC_BITS default constants
  - a fixed_t typedef (logic [15:0])
  - the divider state enum {IDLE, DIVIDE, DONE}
- The multiplier imports the same constants.
- Single module with no sub-module; the FSM, counter and remainder/quotient shift registers all live in fixed_point_divide.

## Test plan
- 0x0300 / 0x0200 (3.0/2.0) -> quotient 0x0180, overflow=0, div_by_zero=0. done exactly 24 cycles after acceptance, one cycle wide.
- 0x8100 / 0x0400 (-1.0/4.0) -> 0x8040. 0x0100 / 0x0300 -> 0x0055 (truncation). 0x8000 / 0x0100 -> 0x0000 (no negative zero).
- 0x7F00 / 0x0080 (127.0/0.5) -> overflow=1. Quotient 0x7FFF with FIXED_DIV_SAT_EN defined; 0x7E00 without it.
- 0x8200 / 0x8000 (divide by negative zero) -> quotient 0x7FFF, div_by_zero=1, overflow=0, latency still 24.
- Pulse start with new operands at E0+5 and again in the DONE cycle -> both ignored; the first result is unchanged and no second done appears. Start at E0+25 is accepted.
- Assert n_rst=0 at E0+10 -> busy, done, quotient and flags all 0 immediately. After release, 0x0300 / 0x0200 completes normally in 24 cycles.
